// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop and lap/clear FSM driving a seconds.centiseconds BCD
// counter that advances on the 100 Hz enable pulse, with a frozen lap display.
module stopwatch_ctrl #(
  parameter int unsigned SEC_WRAP = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_100,
  input  logic        start_pb,
  input  logic        lap_pb,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_hold,
  output logic        wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  localparam logic [3:0] SecMaxTens = 4'((SEC_WRAP - 1) / 10);
  localparam logic [3:0] SecMaxOnes = 4'((SEC_WRAP - 1) % 10);

  state_e      state_q, state_d;
  logic        start_q, lap_q;
  logic [15:0] count_q, count_d;
  logic [15:0] lap_reg_q, lap_reg_d;
  logic        hold_q, hold_d;
  logic        wrap_q, wrap_d;
  logic        start_edge, lap_edge, count_en;

  // Start wins over a simultaneous lap press.
  assign start_edge = start_pb & ~start_q;
  assign lap_edge   = lap_pb & ~lap_q & ~start_edge;
  assign count_en   = tick_100 & (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_edge) state_d = StRun;
      StRun:   if (start_edge) state_d = StPause;
      StPause: begin
        if (start_edge) begin
          state_d = StRun;
        end else if (lap_edge) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    running = (state_q == StRun);
  end

  // BCD ripple increment: {sec_tens, sec_ones, cs_tens, cs_ones}.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (count_en) begin
      if (count_q[3:0] != 4'd9) begin
        count_d[3:0] = count_q[3:0] + 4'd1;
      end else begin
        count_d[3:0] = 4'd0;
        if (count_q[7:4] != 4'd9) begin
          count_d[7:4] = count_q[7:4] + 4'd1;
        end else begin
          count_d[7:4] = 4'd0;
          if (count_q[15:12] == SecMaxTens && count_q[11:8] == SecMaxOnes) begin
            count_d[15:8] = 8'h00;
            wrap_d        = 1'b1;
          end else if (count_q[11:8] != 4'd9) begin
            count_d[11:8] = count_q[11:8] + 4'd1;
          end else begin
            count_d[11:8]  = 4'd0;
            count_d[15:12] = count_q[15:12] + 4'd1;
          end
        end
      end
    end
    if (state_q == StPause && lap_edge) begin
      count_d = 16'h0000;
    end
  end

  always_comb begin
    lap_reg_d = lap_reg_q;
    hold_d    = hold_q;
    if (state_q == StRun && lap_edge) begin
      if (!hold_q) begin
        lap_reg_d = count_q;
        hold_d    = 1'b1;
      end else begin
        hold_d = 1'b0;
      end
    end else if (state_q == StPause && lap_edge) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      lap_q     <= 1'b0;
      count_q   <= 16'h0000;
      lap_reg_q <= 16'h0000;
      hold_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      start_q   <= start_pb;
      lap_q     <= lap_pb;
      count_q   <= count_d;
      lap_reg_q <= lap_reg_d;
      hold_q    <= hold_d;
      wrap_q    <= wrap_d;
    end
  end

  assign disp_bcd = hold_q ? lap_reg_q : count_q;
  assign lap_hold = hold_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: integer-centisecond reference model checked every cycle,
// plus directed literal checks following the scenario list.
module tb_stopwatch_ctrl;

  localparam int SecWrap = 60;
  localparam int Modulus = SecWrap * 100;
  localparam int MIdle = 0, MRun = 1, MPause = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_100 = 1'b0;
  logic        start_pb = 1'b0;
  logic        lap_pb = 1'b0;
  logic [15:0] disp_bcd;
  logic        running, lap_hold, wrap;

  int n_vec = 0;
  int n_miss = 0;
  int wrap_seen = 0;

  // Reference model state
  int   m_state, m_cnt, m_lap;
  logic m_hold, m_wrap, m_sp, m_lp;

  stopwatch_ctrl #(.SEC_WRAP(SecWrap)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_100 (tick_100),
    .start_pb (start_pb),
    .lap_pb   (lap_pb),
    .disp_bcd (disp_bcd),
    .running  (running),
    .lap_hold (lap_hold),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int v);
    int s, c;
    s = v / 100;
    c = v % 100;
    return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = MIdle; m_cnt = 0; m_lap = 0;
      m_hold = 1'b0; m_wrap = 1'b0; m_sp = 1'b0; m_lp = 1'b0;
    end else begin
      logic se, le, counted;
      int old;
      se = start_pb && !m_sp;
      le = lap_pb && !m_lp && !se;
      counted = tick_100 && (m_state == MRun);
      old = m_cnt;
      m_wrap = counted && (old == Modulus - 1);
      if (counted) m_cnt = (old + 1) % Modulus;
      if (m_state == MRun && le) begin
        if (!m_hold) begin
          m_lap = old;
          m_hold = 1'b1;
        end else begin
          m_hold = 1'b0;
        end
      end
      if (se) begin
        m_state = (m_state == MRun) ? MPause : MRun;
      end else if (le && m_state == MPause) begin
        m_state = MIdle; m_cnt = 0; m_hold = 1'b0;
      end
      m_sp = start_pb;
      m_lp = lap_pb;
    end
  end

  always @(negedge clk) begin
    logic [15:0] e_disp;
    e_disp = to_bcd(m_hold ? m_lap : m_cnt);
    n_vec++;
    if (wrap) wrap_seen++;
    if (disp_bcd !== e_disp || running !== (m_state == MRun) || lap_hold !== m_hold ||
        wrap !== m_wrap) begin
      n_miss++;
      $display("FAIL model t=%0t: disp=%h run=%b hold=%b wrap=%b, required disp=%h run=%b hold=%b wrap=%b",
               $time, disp_bcd, running, lap_hold, wrap, e_disp, (m_state == MRun), m_hold,
               m_wrap);
    end
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick_100 = 1'b1; cyc();
      tick_100 = 1'b0; cyc();
    end
  endtask

  task automatic press_start();
    start_pb = 1'b1; cyc();
    start_pb = 1'b0; cyc();
  endtask

  task automatic press_lap();
    lap_pb = 1'b1; cyc();
    lap_pb = 1'b0; cyc();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_disp", disp_bcd, 16'h0000);
    chk("reset_flags", {13'd0, running, lap_hold, wrap}, 16'h0000);
    rst_n = 1'b1;
    cyc();

    // 1: start then 150 ticks
    wrap_seen = 0;
    press_start();
    chk("t1_running", {15'd0, running}, 16'h0001);
    ticks(150);
    chk("t1_disp", disp_bcd, 16'h0150);
    chk("t1_no_wrap", 16'(wrap_seen), 16'h0000);

    // 2: run up to 59.99 then roll over
    ticks(5999 - 150);
    chk("t2_pre", disp_bcd, 16'h5999);
    wrap_seen = 0;
    tick_100 = 1'b1; cyc();
    tick_100 = 1'b0;
    chk("t2_disp", disp_bcd, 16'h0000);
    chk("t2_wrap", {15'd0, wrap}, 16'h0001);
    cyc();
    chk("t2_wrap_drop", {15'd0, wrap}, 16'h0000);
    chk("t2_running", {15'd0, running}, 16'h0001);
    chk("t2_wrap_count", 16'(wrap_seen), 16'h0001);

    // 3: lap freeze and release
    ticks(327);
    press_lap();
    chk("t3_hold", {15'd0, lap_hold}, 16'h0001);
    chk("t3_frozen", disp_bcd, 16'h0327);
    ticks(50);
    chk("t3_still_frozen", disp_bcd, 16'h0327);
    press_lap();
    chk("t3_release", disp_bcd, 16'h0377);
    chk("t3_hold_off", {15'd0, lap_hold}, 16'h0000);

    // 4: pause, ticks ignored, clear
    ticks(1234 - 377);
    press_start();
    ticks(20);
    chk("t4_paused", disp_bcd, 16'h1234);
    press_lap();
    chk("t4_clear", disp_bcd, 16'h0000);
    chk("t4_idle", {15'd0, running}, 16'h0000);

    // 5: simultaneous start/lap with tick in RUN
    press_start();
    ticks(5);
    start_pb = 1'b1; lap_pb = 1'b1; tick_100 = 1'b1;
    cyc();
    start_pb = 1'b0; lap_pb = 1'b0; tick_100 = 1'b0;
    chk("t5_disp", disp_bcd, 16'h0006);
    chk("t5_paused", {14'd0, running, lap_hold}, 16'h0000);
    cyc();

    // 6: async reset with a held button
    press_start();
    ticks(745 - 6);
    chk("t6_pre", disp_bcd, 16'h0745);
    start_pb = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_disp", disp_bcd, 16'h0000);
    chk("t6_reset_flags", {13'd0, running, lap_hold, wrap}, 16'h0000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    chk("t6_held_edge", {15'd0, running}, 16'h0001);
    start_pb = 1'b0;
    ticks(3);
    chk("t6_after", disp_bcd, 16'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
